// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } seq_state_t;

  // Hold and gap counts share one counter sized for the larger of the two.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stagger);
    int unsigned m;
    m = (hold_cycles > stagger) ? hold_cycles : stagger;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int unsigned num_ch,
                                   input int unsigned sync_stages,
                                   input int unsigned hold_cycles,
                                   input int unsigned stagger);
    return (num_ch >= 1) && (sync_stages >= 2) && (hold_cycles >= 1) && (stagger >= 1);
  endfunction

endpackage

// File: rtl/arst_sync_hi.sv
// Active-high reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clocks.
module arst_sync_hi #(
  parameter int unsigned SYNC_STAGES = 4
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all channels in reset, then releases them in order, STAGGER cycles apart.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned SYNC_STAGES = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGGER     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGGER);
  localparam int unsigned IW = $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  if (!params_ok(NUM_CH, SYNC_STAGES, HOLD_CYCLES, STAGGER)) begin : g_param_check
    $error("rst_sequencer: parameter out of range");
  end

  logic              rst_sync;
  seq_state_t        state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [NUM_CH-1:0] rst_o_nx;
  logic              done_nx;

  arst_sync_hi #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_o  <= '1;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      rst_o  <= rst_o_nx;
      done_o <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rst_o_nx = rst_o;
    done_nx  = done_o;

    case (state)
      HOLD: begin
        rst_o_nx = '1;
        done_nx  = 1'b0;
        idx_nx   = '0;
        if (rst_sync) begin
          cnt_nx = '0;
        end else if (cnt == HOLD_TC) begin
          cnt_nx   = '0;
          rst_o_nx = ~NUM_CH'(1);
          if (NUM_CH == 1) begin
            state_nx = RUN;
            done_nx  = 1'b1;
          end else begin
            state_nx = RELEASE;
            idx_nx   = IW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      RELEASE: begin
        if (cnt == GAP_TC) begin
          cnt_nx   = '0;
          rst_o_nx = rst_o & ~(NUM_CH'(1) << idx);
          if (idx == LAST_IDX) begin
            state_nx = RUN;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      RUN: begin
        rst_o_nx = '0;
        done_nx  = 1'b1;
      end

      default: begin
        state_nx = HOLD;
        rst_o_nx = '1;
        done_nx  = 1'b0;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase

    // A software request overrides everything above, including a release due on this edge.
    if (sw_rst_req_i) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      rst_o_nx = '1;
      done_nx  = 1'b0;
    end
  end

endmodule
